// File: rtl/inst_data_sram_responder.sv
// Single-port SRAM slave for the core's sram bus: word-addressed array, RD_LATENCY-deep
// read pipeline, range/alignment error reporting, and saturating access counters.
module inst_data_sram_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] ERR_DATA   = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic        sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_rvalid,
    output logic        sram_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Configuration sanity checks; these fire during elaboration.
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "inst_data_sram_responder: RD_LATENCY must be in 1..4");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
        $fatal(1, "inst_data_sram_responder: ADDR_WIDTH must be in 1..29");
    end

    logic [31:0]           mem [0:DEPTH-1];
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] index;
    logic [1:0]            unused_offset_lo;
    logic                  in_range;
    logic                  bad;
    logic                  accept;
    logic                  rd_req;
    logic                  wr_req;

    // Wrapping subtraction: addresses below BASE_ADDR are caught by the explicit compare.
    assign offset           = sram_addr - BASE_ADDR;
    assign index            = offset[ADDR_WIDTH+1:2];
    assign unused_offset_lo = offset[1:0];
    assign in_range         = (sram_addr >= BASE_ADDR) && (offset[31:ADDR_WIDTH+2] == '0);
    assign bad              = !in_range || (sram_addr[1:0] != 2'b00);

    assign accept = sram_en && !reset;
    assign rd_req = accept && !sram_we;
    assign wr_req = accept && sram_we;

    // Array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_req && !bad) begin
            mem[index] <= sram_wdata;
        end
    end

    // Response pipeline: stage 0 loads at acceptance, the last stage drives the outputs.
    // Data stages only load behind a valid read so the output holds its last response.
    logic [RD_LATENCY-1:0]       pipe_valid;
    logic [RD_LATENCY-1:0]       pipe_err;
    logic [RD_LATENCY-1:0][31:0] pipe_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_data  <= '0;
        end else begin
            pipe_valid[0] <= rd_req;
            pipe_err[0]   <= accept && bad;
            if (rd_req) begin
                pipe_data[0] <= bad ? ERR_DATA : mem[index];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign sram_rvalid = pipe_valid[RD_LATENCY-1];
    assign sram_err    = pipe_err[RD_LATENCY-1];
    assign sram_rdata  = pipe_data[RD_LATENCY-1];

    // Counters include erroneous requests and stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_req && (rd_cnt != 32'hFFFFFFFF)) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_req && (wr_cnt != 32'hFFFFFFFF)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_data_sram_responder.sv
// Directed bench for inst_data_sram_responder at read latencies 1, 3 and 4.
module tb_inst_data_sram_responder;

    localparam logic [2:0]  S1   = 3'b001;
    localparam logic [2:0]  S3   = 3'b010;
    localparam logic [2:0]  S4   = 3'b100;
    localparam logic [31:0] ERR1 = 32'hDEADBEEF;

    logic        clk;
    logic        reset;
    logic        en1, en3, en4;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata1, rdata3, rdata4;
    logic        rvalid1, rvalid3, rvalid4;
    logic        err1, err3, err4;
    logic [31:0] rdcnt1, rdcnt3, rdcnt4;
    logic [31:0] wrcnt1, wrcnt3, wrcnt4;

    int checks = 0;
    int errors = 0;

    inst_data_sram_responder #(.RD_LATENCY(1), .ERR_DATA(ERR1)) u_l1 (
        .clk(clk), .reset(reset), .sram_en(en1), .sram_we(we), .sram_addr(addr),
        .sram_wdata(wdata), .sram_rdata(rdata1), .sram_rvalid(rvalid1), .sram_err(err1),
        .rd_cnt(rdcnt1), .wr_cnt(wrcnt1)
    );

    inst_data_sram_responder #(.RD_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .sram_en(en3), .sram_we(we), .sram_addr(addr),
        .sram_wdata(wdata), .sram_rdata(rdata3), .sram_rvalid(rvalid3), .sram_err(err3),
        .rd_cnt(rdcnt3), .wr_cnt(wrcnt3)
    );

    inst_data_sram_responder #(.RD_LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .sram_en(en4), .sram_we(we), .sram_addr(addr),
        .sram_wdata(wdata), .sram_rdata(rdata4), .sram_rvalid(rvalid4), .sram_err(err4),
        .rd_cnt(rdcnt4), .wr_cnt(wrcnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input logic [2:0] sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
        en1   = sel[0];
        en3   = sel[1];
        en4   = sel[2];
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        en1 = 1'b0;
        en3 = 1'b0;
        en4 = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        addr  = 32'h0;
        wdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rvalid1", 32'(rvalid1), 1'b0);
        chk("rst_err1", 32'(err1), 1'b0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdcnt1", rdcnt1, 32'h0);
        chk("rst_wrcnt1", wrcnt1, 32'h0);
        chk("rst_rdata3", rdata3, 32'h0);
        chk("rst_rvalid4", 32'(rvalid4), 1'b0);

        // Latency 1: write then read the same word on the next cycle.
        req(S1, 1'b1, 32'h1c000010, 32'hCAFEF00D);
        tick();
        chk("wr_no_rvalid", 32'(rvalid1), 1'b0);
        chk("wr_no_err", 32'(err1), 1'b0);
        req(S1, 1'b0, 32'h1c000010, 32'h0);
        tick();
        chk("raw_rvalid", 32'(rvalid1), 1'b1);
        chk("raw_rdata", rdata1, 32'hCAFEF00D);
        chk("raw_err", 32'(err1), 1'b0);
        chk("raw_rdcnt", rdcnt1, 32'd1);
        chk("raw_wrcnt", wrcnt1, 32'd1);

        // Erroneous reads interleaved with a good one.
        req(S1, 1'b0, 32'h1bfffffc, 32'h0);
        tick();
        chk("below_rvalid", 32'(rvalid1), 1'b1);
        chk("below_rdata", rdata1, ERR1);
        chk("below_err", 32'(err1), 1'b1);
        req(S1, 1'b0, 32'h1c000010, 32'h0);
        tick();
        chk("good_rdata", rdata1, 32'hCAFEF00D);
        chk("good_err", 32'(err1), 1'b0);
        req(S1, 1'b0, 32'h1c004000, 32'h0);
        tick();
        chk("above_rvalid", 32'(rvalid1), 1'b1);
        chk("above_rdata", rdata1, ERR1);
        chk("above_err", 32'(err1), 1'b1);
        req(S1, 1'b0, 32'h1c000002, 32'h0);
        tick();
        chk("misal_rvalid", 32'(rvalid1), 1'b1);
        chk("misal_rdata", rdata1, ERR1);
        chk("misal_err", 32'(err1), 1'b1);

        // Last word of the window is in range.
        req(S1, 1'b1, 32'h1c003ffc, 32'hA5A55A5A);
        tick();
        chk("top_wr_rvalid", 32'(rvalid1), 1'b0);
        chk("top_wr_err", 32'(err1), 1'b0);
        chk("top_wr_hold", rdata1, ERR1);
        req(S1, 1'b0, 32'h1c003ffc, 32'h0);
        tick();
        chk("top_rd_rvalid", 32'(rvalid1), 1'b1);
        chk("top_rd_rdata", rdata1, 32'hA5A55A5A);
        chk("top_rd_err", 32'(err1), 1'b0);

        // A misaligned write must leave the word untouched and flag err without rvalid.
        req(S1, 1'b1, 32'h1c000004, 32'h12345678);
        tick();
        req(S1, 1'b1, 32'h1c000006, 32'hFFFFFFFF);
        tick();
        chk("badwr_rvalid", 32'(rvalid1), 1'b0);
        chk("badwr_err", 32'(err1), 1'b1);
        chk("badwr_hold", rdata1, 32'hA5A55A5A);
        req(S1, 1'b0, 32'h1c000004, 32'h0);
        tick();
        chk("prior_rvalid", 32'(rvalid1), 1'b1);
        chk("prior_rdata", rdata1, 32'h12345678);
        chk("prior_err", 32'(err1), 1'b0);
        chk("l1_rdcnt", rdcnt1, 32'd7);
        chk("l1_wrcnt", wrcnt1, 32'd4);

        // Idle: response data holds, counters hold.
        idle();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_rvalid", 32'(rvalid1), 1'b0);
            chk("idle_err", 32'(err1), 1'b0);
            chk("idle_rdata", rdata1, 32'h12345678);
            chk("idle_rdcnt", rdcnt1, 32'd7);
            chk("idle_wrcnt", wrcnt1, 32'd4);
        end

        // Latency 3: back-to-back reads come out in order, three cycles after acceptance.
        req(S3, 1'b1, 32'h1c000000, 32'd1);
        tick();
        req(S3, 1'b1, 32'h1c000004, 32'd2);
        tick();
        req(S3, 1'b1, 32'h1c000008, 32'd3);
        tick();
        req(S3, 1'b0, 32'h1c000000, 32'h0);
        tick();
        chk("l3_c1_rvalid", 32'(rvalid3), 1'b0);
        req(S3, 1'b0, 32'h1c000004, 32'h0);
        tick();
        chk("l3_c2_rvalid", 32'(rvalid3), 1'b0);
        req(S3, 1'b0, 32'h1c000008, 32'h0);
        tick();
        chk("l3_c3_rvalid", 32'(rvalid3), 1'b1);
        chk("l3_c3_rdata", rdata3, 32'd1);
        idle();
        tick();
        chk("l3_c4_rvalid", 32'(rvalid3), 1'b1);
        chk("l3_c4_rdata", rdata3, 32'd2);
        tick();
        chk("l3_c5_rvalid", 32'(rvalid3), 1'b1);
        chk("l3_c5_rdata", rdata3, 32'd3);
        chk("l3_c5_err", 32'(err3), 1'b0);
        tick();
        chk("l3_c6_rvalid", 32'(rvalid3), 1'b0);
        chk("l3_c6_hold", rdata3, 32'd3);
        chk("l3_rdcnt", rdcnt3, 32'd3);
        chk("l3_wrcnt", wrcnt3, 32'd3);

        // Latency 4: reset while two reads are in flight, with a write on the reset edge.
        req(S4, 1'b1, 32'h1c000020, 32'h0BADF00D);
        tick();
        req(S4, 1'b0, 32'h1c000020, 32'h0);
        tick();
        chk("l4_f1_rvalid", 32'(rvalid4), 1'b0);
        req(S4, 1'b0, 32'h1c000020, 32'h0);
        tick();
        chk("l4_f2_rvalid", 32'(rvalid4), 1'b0);
        idle();
        tick();
        chk("l4_f3_rvalid", 32'(rvalid4), 1'b0);
        chk("l4_pre_rdcnt", rdcnt4, 32'd2);
        chk("l4_pre_wrcnt", wrcnt4, 32'd1);
        reset = 1'b1;
        req(S4, 1'b1, 32'h1c000020, 32'hFFFFFFFF);
        tick();
        reset = 1'b0;
        idle();
        chk("l4_rst_rvalid", 32'(rvalid4), 1'b0);
        chk("l4_rst_err", 32'(err4), 1'b0);
        chk("l4_rst_rdata", rdata4, 32'h0);
        chk("l4_rst_rdcnt", rdcnt4, 32'h0);
        chk("l4_rst_wrcnt", wrcnt4, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("l4_flush_rvalid", 32'(rvalid4), 1'b0);
        end
        req(S4, 1'b0, 32'h1c000020, 32'h0);
        tick();
        chk("l4_r1_rvalid", 32'(rvalid4), 1'b0);
        idle();
        tick();
        chk("l4_r2_rvalid", 32'(rvalid4), 1'b0);
        tick();
        chk("l4_r3_rvalid", 32'(rvalid4), 1'b0);
        tick();
        chk("l4_r4_rvalid", 32'(rvalid4), 1'b1);
        chk("l4_r4_rdata", rdata4, 32'h0BADF00D);
        chk("l4_r4_err", 32'(err4), 1'b0);
        chk("l4_post_rdcnt", rdcnt4, 32'd1);
        chk("l4_post_wrcnt", wrcnt4, 32'd0);

        // Saturation on the latency-3 instance; its array survived the reset above.
        force u_l3.rd_cnt = 32'hFFFFFFFE;
        #1;
        release u_l3.rd_cnt;
        chk("sat_preset", rdcnt3, 32'hFFFFFFFE);
        req(S3, 1'b0, 32'h1c000000, 32'h0);
        tick();
        chk("sat_rd1", rdcnt3, 32'hFFFFFFFF);
        req(S3, 1'b0, 32'h1c000004, 32'h0);
        tick();
        chk("sat_rd2", rdcnt3, 32'hFFFFFFFF);
        req(S3, 1'b0, 32'h1c000008, 32'h0);
        tick();
        chk("sat_rd3", rdcnt3, 32'hFFFFFFFF);
        chk("sat_d1_rvalid", 32'(rvalid3), 1'b1);
        chk("sat_d1_rdata", rdata3, 32'd1);
        idle();
        tick();
        chk("sat_d2_rdata", rdata3, 32'd2);
        chk("sat_hold", rdcnt3, 32'hFFFFFFFF);
        tick();
        chk("sat_d3_rdata", rdata3, 32'd3);
        chk("sat_wrcnt", wrcnt3, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_data_sram_responder.md
Name: inst_data_sram_responder

Overview:
- Synchronous single-port SRAM responder: the slave end of the CPU's sram interface (en/we/addr/wdata out of the core, rdata back).
- Instantiated twice in the SoC wrapper, once for instruction fetch and once for data.
- Adds a configurable read latency, address range/alignment checking, and access counters for the trace and debug environment.
- Accepts one request per cycle. No backpressure.

Parameters:
- ADDR_WIDTH, 12, log2 of depth in 32-bit words (4096 words).
- BASE_ADDR, 32'h1c000000, byte address mapped to word 0.
- RD_LATENCY, 1, cycles from request acceptance to rdata valid; legal range 1..4.
- ERR_DATA, 32'h00000000, rdata value returned for an erroneous read.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- sram_en  input  1  request valid this cycle
- sram_we  input  1  1 = write, 0 = read; ignored when sram_en=0
- sram_addr  input  32  byte address
- sram_wdata  input  32  write data
- sram_rdata  output  32  read data
- sram_rvalid  output  1  sram_rdata carries a read response this cycle
- sram_err  output  1  response-aligned error pulse (range or alignment)
- rd_cnt  output  32  accepted reads, saturating
- wr_cnt  output  32  accepted writes, saturating

Behaviour:
- Reset values: sram_rdata=0, sram_rvalid=0, sram_err=0, rd_cnt=0, wr_cnt=0. Response pipeline is cleared.
- Memory array is NOT cleared by reset; contents survive reset.
- Acceptance: a request is accepted on any rising edge with sram_en=1 and reset=0.
- Offset = sram_addr - BASE_ADDR, computed 32-bit modulo.
- Index = offset[ADDR_WIDTH+1:2].
- Request is in range iff sram_addr >= BASE_ADDR (unsigned) and offset[31:ADDR_WIDTH+2]==0.
- bad = out of range OR sram_addr[1:0]!=0.
- Write: if !bad, mem[index] <= sram_wdata at the acceptance edge. If bad, the array is untouched. No rvalid is ever produced for a write.
- Read: the array is sampled at the acceptance edge and reflects every write accepted on earlier edges.
  - A write at cycle T followed by a read of the same word at T+1 returns the new data.
  - Data moves through a pipeline of depth RD_LATENCY.
  - sram_rvalid=1 and sram_rdata are presented in cycle T+RD_LATENCY, where T is the acceptance cycle.
  - A bad read returns ERR_DATA.
- sram_rdata holds the last response value while sram_rvalid=0. It is not zeroed.
- sram_err: one-cycle pulse.
  - Bad read: in the same cycle as its rvalid.
  - Bad write: at T+RD_LATENCY, with sram_rvalid=0.
- Back-to-back requests: full throughput, one per cycle, in order. Responses never reorder or merge.
- Counters:
  - rd_cnt increments on each accepted read; wr_cnt on each accepted write.
  - Bad requests are still counted.
  - Both counters hold at 32'hFFFFFFFF (saturate, no wrap).
- Reset mid-operation: all in-flight responses are discarded. sram_rvalid/sram_err are 0 from the first cycle after the reset edge. Counters return to 0. A write accepted on the edge before reset asserts is retained.
- Reset with sram_en=1 on the same edge: request not accepted, no write, no count.
- Index wrap: not possible, because out-of-range addresses are rejected before indexing.
- RD_LATENCY outside 1..4 is a configuration error: simulation-only check, $fatal at time 0.

Test Plan:
- Reset, write 32'hCAFEF00D to 0x1c000010, then read 0x1c000010 on the next cycle (RD_LATENCY=1) -> rvalid=1 with rdata=32'hCAFEF00D one cycle after the read is accepted; err=0; rd_cnt=1, wr_cnt=1.
- RD_LATENCY=3: read 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles after writing 1, 2, 3 -> rvalid high for exactly 3 consecutive cycles starting 3 cycles after the first read, rdata 1, 2, 3 in order.
- Errors (RD_LATENCY=1):
  - Read 0x1bfffffc -> rdata=ERR_DATA, rvalid=1, err=1.
  - Read 0x1c004000 (AW=12) -> same response.
  - Read 0x1c000002 -> same response.
  - Write 0x1c000006 with 32'hFFFFFFFF, then read 0x1c000004 -> returns the prior value; the write produced err=1 with rvalid=0.
- Hold/idle: after a read returning 32'h12345678, drive en=0 for 5 cycles -> rvalid=0, rdata stays 32'h12345678, counters unchanged.
- Reset mid-flight (RD_LATENCY=4): issue 2 reads, assert reset 2 cycles later -> no rvalid ever appears for those reads; counters=0; a word written before the reads still reads back correctly after reset.
- Saturation: force rd_cnt to 32'hFFFFFFFE, issue 3 reads -> rd_cnt=32'hFFFFFFFF and holds.
